// File: rtl/frame_serializer.sv
// Parallel-to-serial framer feeding the 5-bit command/data deserializer.
// Words {data[4:0], command} are buffered in a small FIFO, then sent as 6-cycle frames.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   valid_i, ready_o    input handshake (transfer when both high at a rising edge)
//   data_i, command_i   parallel payload; data bit 4 is sent first, command last
//   data_val_o          frame-start strobe, high only in the first frame cycle
//   ser_data_o          serial bit stream
//   busy_o              frame in progress or inter-frame gap pending
//   level_o             number of words buffered
module frame_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_GAP   = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    input  logic [4:0]                  data_i,
    input  logic                        command_i,
    output logic                        ready_o,
    output logic                        data_val_o,
    output logic                        ser_data_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CMD,
        GAP
    } state_t;

    state_t        state;
    logic [5:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [5:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [3:0]    gap_cnt;
    logic          push;
    logic          pop;

    assign ready_o = !rst_i && (level_o != FULL);
    assign push    = valid_i && ready_o;
    // Only an idle FSM pops, and only on registered occupancy, so a word
    // pushed into an empty FIFO is picked up one edge later.
    assign pop     = (state == IDLE) && (level_o != '0);

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {data_i, command_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level_o <= level_o + 1'b1;
            end else if (pop && !push) begin
                level_o <= level_o - 1'b1;
            end
        end
    end

    // shreg holds the bits still to send, MSB next; bit_cnt counts F1..F4.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            data_val_o <= 1'b0;
            ser_data_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            data_val_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    ser_data_o <= 1'b0;
                    busy_o     <= 1'b0;
                    if (pop) begin
                        shreg      <= {mem[rd_ptr][4:0], 1'b0};
                        ser_data_o <= mem[rd_ptr][5];
                        data_val_o <= 1'b1;
                        busy_o     <= 1'b1;
                        bit_cnt    <= 3'd4;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    ser_data_o <= shreg[5];
                    shreg      <= shreg << 1;
                    busy_o     <= 1'b1;
                    bit_cnt    <= bit_cnt - 1'b1;
                    if (bit_cnt == 3'd1) begin
                        state <= CMD;
                    end
                end
                CMD: begin
                    ser_data_o <= shreg[5];
                    busy_o     <= 1'b1;
                    // With no gap, IDLE pops on the very next edge, so
                    // frames stay back-to-back at a 6-cycle period.
                    if (IDLE_GAP == 0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= 4'(IDLE_GAP);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    ser_data_o <= 1'b0;
                    busy_o     <= 1'b1;
                    gap_cnt    <= gap_cnt - 1'b1;
                    if (gap_cnt <= 4'd1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Self-checking bench for frame_serializer: two instances (gap 0 and gap 3)
// compared every cycle against a frame-timeline reference model.
module tb_frame_serializer;

    localparam int D = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      valid;
    logic [1:0][4:0] data;
    logic [1:0]      cmd;
    logic [1:0]      ready;
    logic [1:0]      dval;
    logic [1:0]      ser;
    logic [1:0]      busy;
    logic [1:0][2:0] level;

    int         vectors = 0;
    int         miscompares = 0;
    int         t;
    int         gap [2] = '{0, 3};
    int         n [2];
    int         pstart [2];
    int         acc_t [2][256];
    int         st [2][256];
    logic [5:0] wd [2][256];
    logic [5:0] word [2];
    logic       hold [2];

    always #5 clk = ~clk;

    frame_serializer #(.FIFO_DEPTH(D), .IDLE_GAP(0)) u_dut0 (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid[0]),
        .data_i     (data[0]),
        .command_i  (cmd[0]),
        .ready_o    (ready[0]),
        .data_val_o (dval[0]),
        .ser_data_o (ser[0]),
        .busy_o     (busy[0]),
        .level_o    (level[0])
    );

    frame_serializer #(.FIFO_DEPTH(D), .IDLE_GAP(3)) u_dut1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid[1]),
        .data_i     (data[1]),
        .command_i  (cmd[1]),
        .ready_o    (ready[1]),
        .data_val_o (dval[1]),
        .ser_data_o (ser[1]),
        .busy_o     (busy[1]),
        .level_o    (level[1])
    );

    // Words buffered after edge t: accepted so far minus started so far.
    function automatic int model_level(input int i);
        int l = 0;
        for (int k = 0; k < n[i]; k++) begin
            if (acc_t[i][k] <= t) l++;
            if (st[i][k] <= t) l--;
        end
        return l;
    endfunction

    // Outputs after edge t, from each word's frame start time.
    function automatic void model_out(input int i, output logic ev,
                                      output logic es, output logic eb);
        ev = 1'b0;
        es = 1'b0;
        eb = 1'b0;
        for (int k = 0; k < n[i]; k++) begin
            if (t >= st[i][k] && t <= st[i][k] + 5) begin
                ev = (t == st[i][k]);
                es = wd[i][k][5 - (t - st[i][k])];
            end
            if (t >= st[i][k] && t <= st[i][k] + 5 + gap[i]) eb = 1'b1;
        end
    endfunction

    task automatic check_all(input string tag);
        logic ev, es, eb, er;
        int   el;
        for (int i = 0; i < 2; i++) begin
            model_out(i, ev, es, eb);
            el = model_level(i);
            er = !rst && (el != D);
            vectors++;
            assert (dval[i] === ev) else begin
                miscompares++;
                $error("FAIL %s dval%0d got %b want %b", tag, i, dval[i], ev);
            end
            vectors++;
            assert (ser[i] === es) else begin
                miscompares++;
                $error("FAIL %s ser%0d got %b want %b", tag, i, ser[i], es);
            end
            vectors++;
            assert (busy[i] === eb) else begin
                miscompares++;
                $error("FAIL %s busy%0d got %b want %b", tag, i, busy[i], eb);
            end
            vectors++;
            assert (level[i] === 3'(el)) else begin
                miscompares++;
                $error("FAIL %s level%0d got %0d want %0d", tag, i, level[i], el);
            end
            vectors++;
            assert (ready[i] === er) else begin
                miscompares++;
                $error("FAIL %s ready%0d got %b want %b", tag, i, ready[i], er);
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            n[i] = 0;
            pstart[i] = -100;
            hold[i] = 1'b0;
            valid[i] = 1'b0;
            word[i] = '0;
        end
    endtask

    // One clock: new random word unless one is held, apply, advance, check.
    task automatic step(input int p0, input int p1);
        int   pr [2];
        logic mr [2];
        int   s;
        pr[0] = p0;
        pr[1] = p1;
        for (int i = 0; i < 2; i++) begin
            if (!hold[i]) begin
                valid[i] = (int'($urandom_range(99)) < pr[i]);
                word[i] = 6'($urandom);
            end
            data[i] = word[i][5:1];
            cmd[i] = word[i][0];
            mr[i] = (model_level(i) != D);
        end
        @(posedge clk);
        t++;
        for (int i = 0; i < 2; i++) begin
            if (valid[i] && mr[i] && n[i] < 256) begin
                s = pstart[i] + 6 + gap[i];
                if (t + 1 > s) s = t + 1;
                acc_t[i][n[i]] = t;
                st[i][n[i]] = s;
                wd[i][n[i]] = word[i];
                pstart[i] = s;
                n[i]++;
                hold[i] = 1'b0;
            end else begin
                hold[i] = valid[i];
            end
        end
        @(negedge clk);
        check_all("step");
    endtask

    // Directed push of one word to each instance, waiting out any held word.
    task automatic put(input logic [5:0] w0, input logic [5:0] w1);
        for (int k = 0; k < 50 && (hold[0] || hold[1]); k++) step(0, 0);
        word[0] = w0;
        word[1] = w1;
        valid = 2'b11;
        hold[0] = 1'b1;
        hold[1] = 1'b1;
        step(0, 0);
    endtask

    initial begin
        t = 0;
        rst = 1'b1;
        data = '0;
        cmd = '0;
        clear_model();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        #1;
        check_all("post_reset");

        put(6'b101101, 6'b101101);
        repeat (12) step(0, 0);

        for (int k = 0; k < 6; k++) put(6'(k * 11 + 3), 6'(k * 7 + 40));
        repeat (40) step(0, 0);

        for (int k = 0; k < 10; k++) put(6'($urandom), 6'($urandom));
        repeat (70) step(0, 0);

        repeat (200) step(90, 90);
        repeat (40) step(0, 0);

        put(6'b110010, 6'b011101);
        repeat (3) step(0, 0);
        rst = 1'b1;
        clear_model();
        #1;
        check_all("reset_mid");
        @(negedge clk);
        check_all("reset_hold");
        rst = 1'b0;
        #1;
        check_all("reset_release");
        put(6'b011011, 6'b100110);
        repeat (12) step(0, 0);

        repeat (200) step(25, 25);
        repeat (40) step(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
